// File: rtl/medidor_pkg.sv
// medidor_pkg: shared FSM state encoding and default counter width for the period meter.
package medidor_pkg;
    typedef enum logic [1:0] {
        ESPERA = 2'd0,
        ALTO   = 2'd1,
        BAJO   = 2'd2
    } estado_t;
    localparam int ANCHO_DEF = 20;
endpackage

// File: rtl/detector_flanco.sv
// detector_flanco: 2-flop synchronizer plus previous-value flop; emits one-cycle rise/fall pulses.
module detector_flanco (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_senal,
    output logic o_sube,
    output logic o_baja
);
    logic s1_q, s2_q, prev_q;
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= i_senal;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end
    assign o_sube = s2_q & ~prev_q;
    assign o_baja = ~s2_q & prev_q;
endmodule

// File: rtl/medidor_periodo.sv
// medidor_periodo: measures period and high time of an asynchronous square wave in clock cycles,
// flagging loss of signal when no rising edge arrives within LIMITE cycles.
module medidor_periodo
    import medidor_pkg::*;
#(
    parameter int ANCHO  = ANCHO_DEF,
    parameter int LIMITE = 2**ANCHO-1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_senal,
    output logic [ANCHO-1:0] o_periodo,
    output logic [ANCHO-1:0] o_alto,
    output logic             o_valido,
    output logic             o_sin_senal
);
    localparam logic [ANCHO-1:0] LIM = ANCHO'(LIMITE);
    localparam logic [ANCHO-1:0] UNO = ANCHO'(1);
    estado_t          estado_q, estado_d;
    logic [ANCHO-1:0] cnt_periodo_q, cnt_periodo_d;
    logic [ANCHO-1:0] cnt_alto_q, cnt_alto_d;
    logic [ANCHO-1:0] alto_cap_q, alto_cap_d;
    logic [ANCHO-1:0] periodo_q, periodo_d;
    logic [ANCHO-1:0] alto_q, alto_d;
    logic             valido_q, valido_d;
    logic             sin_q, sin_d;
    logic             sube, baja, limite;

    detector_flanco u_detector (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .i_senal(i_senal),
        .o_sube (sube),
        .o_baja (baja)
    );

    assign limite = cnt_periodo_q == LIM;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            estado_q      <= ESPERA;
            cnt_periodo_q <= '0;
            cnt_alto_q    <= '0;
            alto_cap_q    <= '0;
            periodo_q     <= '0;
            alto_q        <= '0;
            valido_q      <= 1'b0;
            sin_q         <= 1'b1;
        end else begin
            estado_q      <= estado_d;
            cnt_periodo_q <= cnt_periodo_d;
            cnt_alto_q    <= cnt_alto_d;
            alto_cap_q    <= alto_cap_d;
            periodo_q     <= periodo_d;
            alto_q        <= alto_d;
            valido_q      <= valido_d;
            sin_q         <= sin_d;
        end
    end

    // A rise always wins over the timeout so a period of exactly LIMITE is still reported.
    always_comb begin
        estado_d      = estado_q;
        cnt_periodo_d = cnt_periodo_q;
        cnt_alto_d    = cnt_alto_q;
        alto_cap_d    = alto_cap_q;
        periodo_d     = periodo_q;
        alto_d        = alto_q;
        valido_d      = 1'b0;
        sin_d         = sin_q;
        case (estado_q)
            ESPERA: begin
                if (sube) begin
                    estado_d      = ALTO;
                    cnt_periodo_d = UNO;
                    cnt_alto_d    = UNO;
                end
            end
            ALTO: begin
                if (limite) begin
                    estado_d = ESPERA;
                    sin_d    = 1'b1;
                end else if (baja) begin
                    estado_d      = BAJO;
                    alto_cap_d    = cnt_alto_q;
                    cnt_periodo_d = cnt_periodo_q + UNO;
                end else begin
                    cnt_periodo_d = cnt_periodo_q + UNO;
                    cnt_alto_d    = cnt_alto_q + UNO;
                end
            end
            BAJO: begin
                if (sube) begin
                    estado_d      = ALTO;
                    periodo_d     = cnt_periodo_q;
                    alto_d        = alto_cap_q;
                    valido_d      = 1'b1;
                    sin_d         = 1'b0;
                    cnt_periodo_d = UNO;
                    cnt_alto_d    = UNO;
                end else if (limite) begin
                    estado_d = ESPERA;
                    sin_d    = 1'b1;
                end else begin
                    cnt_periodo_d = cnt_periodo_q + UNO;
                end
            end
            default: estado_d = ESPERA;
        endcase
    end

    assign o_periodo   = periodo_q;
    assign o_alto      = alto_q;
    assign o_valido    = valido_q;
    assign o_sin_senal = sin_q;
endmodule

// File: tb/tb_medidor_periodo.sv
// tb_medidor_periodo: directed waveforms; expected period/high pairs are queued at each completing
// rise and a negedge monitor pops one per o_valido strobe.
module tb_medidor_periodo;
    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_senal = 1'b0;
    logic [19:0] o_periodo, o_alto;
    logic        o_valido, o_sin_senal;
    int          total = 0;
    int          bad = 0;
    logic [39:0] q[$];
    bit          armed = 1'b0;
    int          last_h = 0, last_l = 0;

    medidor_periodo #(.ANCHO(20), .LIMITE(63)) dut (
        .i_clock    (clk),
        .i_reset    (i_reset),
        .i_senal    (i_senal),
        .o_periodo  (o_periodo),
        .o_alto     (o_alto),
        .o_valido   (o_valido),
        .o_sin_senal(o_sin_senal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!i_reset && o_valido) begin
            if (q.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                logic [39:0] e;
                e = q.pop_front();
                chk("periodo", int'(o_periodo), int'(e[39:20]));
                chk("alto", int'(o_alto), int'(e[19:0]));
                chk("sin_senal_at_strobe", int'(o_sin_senal), 0);
            end
        end
    end

    // Called at posedge+1; one segment = h cycles high then l cycles low.
    task automatic seg(input int h, input int l);
        if (armed) q.push_back({20'(last_h + last_l), 20'(last_h)});
        armed = 1'b1;
        last_h = h;
        last_l = l;
        i_senal = 1'b1;
        repeat (h) @(posedge clk);
        #1 i_senal = 1'b0;
        repeat (l) @(posedge clk);
        #1;
    endtask

    task automatic wait_sin(input string name, input int start, input int exp);
        int n;
        n = start;
        while (!o_sin_senal && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk(name, n, exp);
        armed = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_periodo", int'(o_periodo), 0);
        chk("rst_alto", int'(o_alto), 0);
        chk("rst_valido", int'(o_valido), 0);
        chk("rst_sin", int'(o_sin_senal), 1);
        @(negedge clk) i_reset = 1'b0;
        @(posedge clk);
        #1;
        repeat (5) seg(10, 10);
        chk("sin_running", int'(o_sin_senal), 0);
        wait_sin("timeout_low_cycles", 20, 66);
        chk("held_periodo", int'(o_periodo), 20);
        chk("held_alto", int'(o_alto), 10);
        repeat (3) seg(10, 10);
        repeat (4) seg(3, 7);
        repeat (3) seg(7, 3);
        repeat (6) seg(1, 1);
        repeat (3) seg(1, 62);
        chk("sin_at_limit_rise", int'(o_sin_senal), 0);
        q.push_back({20'd63, 20'd1});
        i_senal = 1'b1;
        wait_sin("timeout_high_cycles", 0, 66);
        chk("held_periodo_63", int'(o_periodo), 63);
        chk("held_alto_1", int'(o_alto), 1);
        @(posedge clk);
        #1 i_senal = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        repeat (2) seg(10, 10);
        q.push_back({20'd20, 20'd10});
        i_senal = 1'b1;
        repeat (6) @(posedge clk);
        #3 i_reset = 1'b1;
        #1;
        chk("async_rst_periodo", int'(o_periodo), 0);
        chk("async_rst_alto", int'(o_alto), 0);
        chk("async_rst_valido", int'(o_valido), 0);
        chk("async_rst_sin", int'(o_sin_senal), 1);
        i_senal = 1'b0;
        repeat (2) @(posedge clk);
        #2 i_reset = 1'b0;
        armed = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        repeat (3) seg(10, 10);
        repeat (10) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
